// File: rtl/vector_sweep_driver.sv
// Sweep driver for the 4-input f/g/h logic block: steps x1..x4 through all 16 vectors,
// captures each {f,g,h} response, counts mismatches against the golden equations and keeps the results.
module vector_sweep_driver #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       x1,
    output logic       x2,
    output logic       x3,
    output logic       x4,
    input  logic       f_in,
    input  logic       g_in,
    input  logic       h_in,
    output logic       busy,
    output logic       done,
    output logic [4:0] mismatch_cnt,
    input  logic [3:0] rd_addr,
    output logic [2:0] rd_data
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_FINISH
    } state_t;

    state_t     state_q;
    logic [3:0] idx_q;
    logic [3:0] settle_cnt_q;
    logic [3:0] x_q;
    logic       busy_q;
    logic       done_q;
    logic [4:0] mismatch_q;
    logic [2:0] mem_q [16];
    logic [2:0] rd_data_q;

    logic [2:0] resp_d;
    logic       miss_d;
    logic [4:0] mismatch_d;

    function automatic logic [2:0] golden_fgh(input logic [3:0] v);
        logic g;
        logic h;
        g = (v[3] & v[1]) | (v[2] & v[0]);
        h = (v[3] | v[1]) & (v[2] | v[0]);
        return {g | h, g, h};
    endfunction

    assign resp_d     = {f_in, g_in, h_in};
    assign miss_d     = (resp_d != golden_fgh(idx_q));
    assign mismatch_d = mismatch_q + {4'd0, miss_d};

    // Sequencer: x, busy and done are registered alongside the state so they change on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            settle_cnt_q <= '0;
            x_q          <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            mismatch_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q      <= S_SETTLE;
                        idx_q        <= '0;
                        settle_cnt_q <= '0;
                        mismatch_q   <= '0;
                        x_q          <= '0;
                        busy_q       <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        state_q <= S_SAMPLE;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 4'd1;
                    end
                end
                S_SAMPLE: begin
                    mismatch_q <= mismatch_d;
                    if (idx_q == 4'd15) begin
                        state_q <= S_FINISH;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        x_q     <= '0;
                    end else begin
                        state_q      <= S_SETTLE;
                        idx_q        <= idx_q + 4'd1;
                        x_q          <= idx_q + 4'd1;
                        settle_cnt_q <= '0;
                    end
                end
                S_FINISH: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Result memory: the read samples the pre-write contents, so a same-edge write returns the old entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_addr];
            if (state_q == S_SAMPLE) begin
                mem_q[idx_q] <= resp_d;
            end
        end
    end

    assign x1           = x_q[3];
    assign x2           = x_q[2];
    assign x3           = x_q[1];
    assign x4           = x_q[0];
    assign busy         = busy_q;
    assign done         = done_q;
    assign mismatch_cnt = mismatch_q;
    assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_vector_sweep_driver.sv
// Bench for vector_sweep_driver: two instances (SETTLE=2 with a combinational response block,
// SETTLE=1 with responses delayed one cycle) driven by random response tables.
module tb_vector_sweep_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic [3:0] rd_addr_a = '0;
    logic [3:0] rd_addr_b = '0;

    logic       x1a, x2a, x3a, x4a, busy_a, done_a;
    logic       x1b, x2b, x3b, x4b, busy_b, done_b;
    logic       fa, ga, ha;
    logic [4:0] mc_a, mc_b;
    logic [2:0] rd_data_a, rd_data_b;
    logic [2:0] resp_b_q = '0;
    logic [3:0] xa, xb;

    logic [2:0] tbl_a [16];
    logic [2:0] tbl_b [16];
    logic [2:0] rd_got [16];

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    assign xa = {x1a, x2a, x3a, x4a};
    assign xb = {x1b, x2b, x3b, x4b};
    assign {fa, ga, ha} = tbl_a[xa];

    always @(posedge clk) resp_b_q <= tbl_b[xb];

    vector_sweep_driver #(.SETTLE(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .x1(x1a), .x2(x2a), .x3(x3a), .x4(x4a),
        .f_in(fa), .g_in(ga), .h_in(ha),
        .busy(busy_a), .done(done_a), .mismatch_cnt(mc_a),
        .rd_addr(rd_addr_a), .rd_data(rd_data_a)
    );

    vector_sweep_driver #(.SETTLE(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .x1(x1b), .x2(x2b), .x3(x3b), .x4(x4b),
        .f_in(resp_b_q[2]), .g_in(resp_b_q[1]), .h_in(resp_b_q[0]),
        .busy(busy_b), .done(done_b), .mismatch_cnt(mc_b),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference response of the golden block for vector index v.
    function automatic logic [2:0] ref_fgh(input int v);
        int  a, b, c, d;
        bit  g, h;
        a = (v / 8) % 2;
        b = (v / 4) % 2;
        c = (v / 2) % 2;
        d = v % 2;
        g = (a * c + b * d) > 0;
        h = ((a + c) > 0) && ((b + d) > 0);
        return {g | h, g, h};
    endfunction

    function automatic int expected_misses_a();
        int n = 0;
        for (int i = 0; i < 16; i++) if (tbl_a[i] != ref_fgh(i)) n++;
        return n;
    endfunction

    function automatic int expected_misses_b();
        int n = 0;
        for (int i = 0; i < 16; i++) if (tbl_b[i] != ref_fgh(i)) n++;
        return n;
    endfunction

    task automatic read_all_a();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rd_addr_a = 4'(i);
            @(posedge clk);
            #1;
            rd_got[i] = rd_data_a;
        end
    endtask

    task automatic read_all_b();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rd_addr_b = 4'(i);
            @(posedge clk);
            #1;
            rd_got[i] = rd_data_b;
        end
    endtask

    // One sweep on instance A; k counts edges after the start edge. Vector k/3 is held while busy.
    task automatic run_a(input string name, input bit extra_pulses);
        int done_k = -1;
        int ndone = 0;
        int xerr = 0;
        int busyerr = 0;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (done_a) begin
                ndone++;
                done_k = k;
            end
            if (done_k < 0) begin
                if (!busy_a) busyerr++;
                if (xa != 4'(k / 3)) xerr++;
            end
            if (extra_pulses) start_a = (k == 10);
            if (done_k >= 0) break;
        end
        check_eq({name, "_done_latency"}, done_k, 48);
        check_eq({name, "_x_sequence"}, xerr, 0);
        check_eq({name, "_busy_during"}, busyerr, 0);
        check_eq({name, "_finish_state"}, {busy_a, xa}, 5'b0_0000);
        if (extra_pulses) begin
            start_a = 1'b1;
            @(posedge clk);
            #1;
            start_a = 1'b0;
            if (done_a) ndone++;
            @(posedge clk);
            #1;
            if (done_a) ndone++;
            check_eq({name, "_late_start_ignored"}, busy_a, 1'b0);
            check_eq({name, "_single_done"}, ndone, 1);
        end
    endtask

    task automatic run_b(input string name);
        int done_k = -1;
        int xerr = 0;
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (done_b) begin
                done_k = k;
                break;
            end
            if (xb != 4'(k / 2)) xerr++;
        end
        check_eq({name, "_done_latency"}, done_k, 32);
        check_eq({name, "_x_sequence"}, xerr, 0);
        check_eq({name, "_count"}, mc_b, expected_misses_b());
        read_all_b();
        for (int i = 0; i < 16; i++) check_eq($sformatf("%s_mem%0d", name, i), rd_got[i], tbl_b[i]);
    endtask

    initial begin
        int held_done_k;
        int held_busy_k;

        for (int i = 0; i < 16; i++) begin
            tbl_a[i] = ref_fgh(i);
            tbl_b[i] = ref_fgh(i);
        end

        // Reset state, no clock edge involved.
        #2 rst = 1'b1;
        #1;
        check_eq("rst_x", xa, 4'h0);
        check_eq("rst_busy", busy_a, 1'b0);
        check_eq("rst_done", done_a, 1'b0);
        check_eq("rst_count", mc_a, 5'd0);
        check_eq("rst_rd_data", rd_data_a, 3'b000);
        #20 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Golden block attached, with ignored start pulses during and at the end of the sweep.
        run_a("golden", 1'b1);
        check_eq("golden_count", mc_a, 5'd0);
        read_all_a();
        for (int i = 0; i < 16; i++) check_eq($sformatf("golden_mem%0d", i), rd_got[i], tbl_a[i]);
        check_eq("golden_rd0", rd_got[0], 3'b000);
        check_eq("golden_rd5", rd_got[5], 3'b110);
        check_eq("golden_rd9", rd_got[9], 3'b101);
        check_eq("golden_rd10", rd_got[10], 3'b110);
        check_eq("golden_rd15", rd_got[15], 3'b111);
        check_eq("golden_count_held", mc_a, 5'd0);

        // f stuck at 0.
        for (int i = 0; i < 16; i++) tbl_a[i] = ref_fgh(i) & 3'b011;
        run_a("fstuck", 1'b0);
        check_eq("fstuck_count", mc_a, 5'd11);
        check_eq("fstuck_count_model", mc_a, expected_misses_a());
        read_all_a();
        check_eq("fstuck_rd15", rd_got[15], 3'b011);

        // Random response tables.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++) tbl_a[i] = 3'($urandom_range(0, 7));
            run_a($sformatf("rand%0d", r), 1'b0);
            check_eq($sformatf("rand%0d_count", r), mc_a, expected_misses_a());
            read_all_a();
            for (int i = 0; i < 16; i++) check_eq($sformatf("rand%0d_mem%0d", r, i), rd_got[i], tbl_a[i]);
        end

        // Start held high: FINISH ignores it, the following IDLE cycle re-triggers.
        held_done_k = -1;
        held_busy_k = -1;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 200; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (done_a && held_done_k < 0) held_done_k = k;
            if (held_done_k >= 0 && k > held_done_k && busy_a) begin
                held_busy_k = k;
                break;
            end
        end
        start_a = 1'b0;
        check_eq("held_done_latency", held_done_k, 48);
        check_eq("held_retrigger", held_busy_k, 50);

        // Reset in the middle of a sweep while vector 7 is driven.
        for (int i = 0; i < 16; i++) tbl_a[i] = 3'($urandom_range(0, 7));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        for (int k = 0; k < 60 && xa != 4'd7; k++) begin
            @(posedge clk);
            #1;
        end
        check_eq("midrst_reached_idx7", xa, 4'd7);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_x", xa, 4'h0);
        check_eq("midrst_busy", busy_a, 1'b0);
        check_eq("midrst_done", done_a, 1'b0);
        check_eq("midrst_count", mc_a, 5'd0);
        check_eq("midrst_rd_data", rd_data_a, 3'b000);
        #1 rst = 1'b0;
        read_all_a();
        for (int i = 0; i < 16; i++) check_eq($sformatf("midrst_mem%0d", i), rd_got[i], 3'b000);
        for (int i = 0; i < 16; i++) tbl_a[i] = 3'($urandom_range(0, 7));
        run_a("restart", 1'b0);
        check_eq("restart_count", mc_a, expected_misses_a());
        read_all_a();
        for (int i = 0; i < 16; i++) check_eq($sformatf("restart_mem%0d", i), rd_got[i], tbl_a[i]);

        // SETTLE=1 instance with one-cycle-delayed responses.
        run_b("s1_golden");
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) tbl_b[i] = 3'($urandom_range(0, 7));
            run_b($sformatf("s1_rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
